// File: rtl/first_fill_frame_ctrl.sv
// first_fill_frame_ctrl: frame sequencer ahead of the First Fill core.
// Frames a 1-bit pixel stream, pulses core_start per frame, awaits done.
module first_fill_frame_ctrl #(
  parameter int IMG_W   = 64,
  parameter int IMG_H   = 64,
  parameter int TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] frame_cfg,
  input  logic       s_tvalid,
  output logic       s_tready,
  input  logic       s_tdata,
  output logic       core_start,
  output logic       core_tvalid,
  input  logic       core_tready,
  output logic       core_tdata,
  output logic       core_tuser,
  output logic       core_tlast,
  input  logic       core_done,
  output logic       busy,
  output logic       run_done,
  output logic [7:0] frames_done,
  output logic       err_timeout
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_STREAM,
    S_WAIT,
    S_NEXT
  } state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [TW-1:0] to_q, to_d;
  logic [7:0]    rem_q, rem_d;
  logic [7:0]    fd_q, fd_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic          run_done_q, run_done_d;
  logic          in_stream;
  logic          xfer;

  assign in_stream   = (state_q == S_STREAM);
  assign s_tready    = core_tready & in_stream & ~abort;
  assign core_tvalid = s_tvalid & in_stream;
  assign core_tdata  = s_tdata;
  assign core_tuser  = (x_q == '0) && (y_q == '0);
  assign core_tlast  = (x_q == X_LAST);
  assign core_start  = (state_q == S_START);
  assign xfer        = s_tvalid & s_tready;

  assign busy        = busy_q;
  assign run_done    = run_done_q;
  assign frames_done = fd_q;
  assign err_timeout = err_q;

  // Next-state and counter logic; abort overrides every state.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    to_d       = to_q;
    rem_d      = rem_q;
    fd_d       = fd_q;
    err_d      = err_q;
    run_done_d = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
      x_d     = '0;
      y_d     = '0;
      to_d    = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            rem_d   = frame_cfg;
            fd_d    = '0;
            err_d   = 1'b0;
            state_d = S_START;
          end
        end
        S_START: begin
          x_d     = '0;
          y_d     = '0;
          state_d = S_STREAM;
        end
        S_STREAM: begin
          if (xfer) begin
            if (x_q == X_LAST) begin
              x_d = '0;
              if (y_q == Y_LAST) begin
                y_d     = '0;
                to_d    = '0;
                state_d = S_WAIT;
              end else begin
                y_d = y_q + 1'b1;
              end
            end else begin
              x_d = x_q + 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (core_done) begin
            state_d = S_NEXT;
          end else if (to_q == T_LAST) begin
            err_d   = 1'b1;
            state_d = S_NEXT;
          end else begin
            to_d = to_q + 1'b1;
          end
        end
        S_NEXT: begin
          fd_d = fd_q + 1'b1;
          if (rem_q == 8'd0) begin
            state_d = S_START;
          end else if (rem_q == 8'd1) begin
            run_done_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            rem_d   = rem_q - 1'b1;
            state_d = S_START;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      to_q       <= '0;
      rem_q      <= '0;
      fd_q       <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      run_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      to_q       <= to_d;
      rem_q      <= rem_d;
      fd_q       <= fd_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      run_done_q <= run_done_d;
    end
  end

endmodule

// File: tb/tb_first_fill_frame_ctrl.sv
// tb_first_fill_frame_ctrl: scoreboard bench, 4x2 frames, TIMEOUT=16.
// Stimulus queues expectations; a negedge monitor pops and compares.
module tb_first_fill_frame_ctrl;

  localparam int SEL_CS   = 0;
  localparam int SEL_RD   = 1;
  localparam int SEL_BUSY = 2;
  localparam int SEL_FD   = 3;
  localparam int SEL_ERR  = 4;
  localparam int SEL_STR  = 5;
  localparam int SEL_CTV  = 6;
  localparam int SEL_PIXQ = 7;
  localparam int SEL_TOF  = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] frame_cfg;
  logic       s_tvalid;
  logic       s_tready;
  logic       s_tdata;
  logic       core_start;
  logic       core_tvalid;
  logic       core_tready;
  logic       core_tdata;
  logic       core_tuser;
  logic       core_tlast;
  logic       core_done;
  logic       busy;
  logic       run_done;
  logic [7:0] frames_done;
  logic       err_timeout;

  typedef struct {
    string      name;
    logic [2:0] bits;
  } pix_t;

  typedef struct {
    string name;
    int    sel;
    int    ev;
  } item_t;

  pix_t  pix_q[$];
  item_t item_q[$];

  int checks = 0;
  int errors = 0;
  bit to_flag = 1'b0;

  // Pixel k of a 4x2 frame: data pattern, SOF on k=0, EOL on k=3,7.
  logic [7:0] pat = 8'b0110_1101;
  logic [7:0] usr = 8'b0000_0001;
  logic [7:0] lst = 8'b1000_1000;

  first_fill_frame_ctrl #(
    .IMG_W  (4),
    .IMG_H  (2),
    .TIMEOUT(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .frame_cfg  (frame_cfg),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .s_tdata    (s_tdata),
    .core_start (core_start),
    .core_tvalid(core_tvalid),
    .core_tready(core_tready),
    .core_tdata (core_tdata),
    .core_tuser (core_tuser),
    .core_tlast (core_tlast),
    .core_done  (core_done),
    .busy       (busy),
    .run_done   (run_done),
    .frames_done(frames_done),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  function automatic int obs(input int sel);
    case (sel)
      SEL_CS:   return int'(core_start);
      SEL_RD:   return int'(run_done);
      SEL_BUSY: return int'(busy);
      SEL_FD:   return int'(frames_done);
      SEL_ERR:  return int'(err_timeout);
      SEL_STR:  return int'(s_tready);
      SEL_CTV:  return int'(core_tvalid);
      SEL_PIXQ: return pix_q.size();
      SEL_TOF:  return int'(to_flag);
      default:  return -1;
    endcase
  endfunction

  // Monitor: pops a pixel per upstream transfer and all queued items.
  initial begin
    pix_t       pe;
    item_t      it;
    logic [3:0] got;
    int         v;
    forever begin
      @(negedge clk);
      if (s_tvalid === 1'b1 && s_tready === 1'b1) begin
        checks++;
        got = {core_tvalid, core_tdata, core_tuser, core_tlast};
        if (pix_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pixel got %b required no transfer", got);
        end else begin
          pe = pix_q.pop_front();
          if (got !== {1'b1, pe.bits}) begin
            errors++;
            $display("FAIL %s got %b required %b", pe.name, got,
                     {1'b1, pe.bits});
          end
        end
      end
      while (item_q.size() != 0) begin
        it = item_q.pop_front();
        checks++;
        v  = obs(it.sel);
        if (v != it.ev) begin
          errors++;
          $display("FAIL %s got %0d required %0d", it.name, v, it.ev);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expc(input string nm, input int sel, input int ev);
    item_q.push_back('{nm, sel, ev});
  endtask

  // Feed npix pixels while in STREAM; optional ready toggling and a
  // core_done pulse coinciding with the last transfer.
  task automatic stream_frame(input bit tog, input bit dol,
                              input int npix);
    int k;
    int g;
    k = 0;
    g = 0;
    while (k < npix && g < 64) begin
      s_tdata     = pat[k];
      core_tready = tog ? ~g[0] : 1'b1;
      core_done   = dol && (k == npix - 1);
      #2;
      if (tog) expc("s_tready_mirror", SEL_STR, int'(core_tready));
      if (s_tready) begin
        pix_q.push_back('{$sformatf("pix%0d", k),
                          {pat[k], usr[k], lst[k]}});
        k++;
      end
      tick();
      g++;
    end
    if (k < npix) to_flag = 1'b1;
    core_tready = 1'b1;
    core_done   = 1'b0;
  endtask

  // Entered in the START cycle; done returned dly cycles after the
  // last pixel; leaves in the following START cycle or idle.
  task automatic do_frame(input bit tog, input int dly, input bit last,
                          input int fd_exp);
    expc("core_start", SEL_CS, 1);
    expc("busy_start", SEL_BUSY, 1);
    tick();
    expc("core_start_low", SEL_CS, 0);
    stream_frame(tog, 1'b0, 8);
    expc("wait_no_ready", SEL_STR, 0);
    repeat (dly - 1) tick();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    expc("next_run_done", SEL_RD, 0);
    expc("next_frames", SEL_FD, fd_exp - 1);
    expc("next_core_start", SEL_CS, 0);
    tick();
    expc("frames_done", SEL_FD, fd_exp);
    if (last) begin
      expc("run_done", SEL_RD, 1);
      expc("busy_idle", SEL_BUSY, 0);
      expc("idle_core_start", SEL_CS, 0);
      tick();
      expc("run_done_pulse_end", SEL_RD, 0);
    end else begin
      expc("run_done_mid", SEL_RD, 0);
    end
  endtask

  task automatic exp_all_zero(input string tag);
    expc({tag, "_cs"}, SEL_CS, 0);
    expc({tag, "_rd"}, SEL_RD, 0);
    expc({tag, "_busy"}, SEL_BUSY, 0);
    expc({tag, "_fd"}, SEL_FD, 0);
    expc({tag, "_err"}, SEL_ERR, 0);
    expc({tag, "_s_tready"}, SEL_STR, 0);
    expc({tag, "_core_tvalid"}, SEL_CTV, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    frame_cfg   = 8'd1;
    s_tvalid    = 1'b1;
    s_tdata     = 1'b0;
    core_tready = 1'b1;
    core_done   = 1'b0;
    repeat (2) tick();
    exp_all_zero("reset");
    tick();
    rst_n = 1'b1;
    tick();
    expc("idle_s_tready", SEL_STR, 0);
    expc("idle_core_tvalid", SEL_CTV, 0);

    // Single frame, ready held high, done 3 cycles after last pixel.
    start = 1'b1;
    tick();
    start = 1'b0;
    do_frame(1'b0, 3, 1'b1, 1);

    // Single frame with core_tready toggling 1,0,1,0.
    start = 1'b1;
    tick();
    start = 1'b0;
    do_frame(1'b1, 3, 1'b1, 1);

    // Three-frame run, done 5 cycles after each last pixel.
    frame_cfg = 8'd3;
    start     = 1'b1;
    tick();
    start = 1'b0;
    do_frame(1'b0, 5, 1'b0, 1);
    do_frame(1'b0, 5, 1'b0, 2);
    do_frame(1'b0, 5, 1'b1, 3);

    // Timeout: done only alongside the last transfer, so it is ignored.
    frame_cfg = 8'd1;
    start     = 1'b1;
    tick();
    start = 1'b0;
    expc("to_core_start", SEL_CS, 1);
    tick();
    stream_frame(1'b0, 1'b1, 8);
    for (int i = 1; i <= 16; i++) begin
      expc($sformatf("err_low_w%0d", i), SEL_ERR, 0);
      expc("to_busy", SEL_BUSY, 1);
      tick();
    end
    expc("err_set", SEL_ERR, 1);
    expc("to_next_rd", SEL_RD, 0);
    tick();
    expc("to_run_done", SEL_RD, 1);
    expc("to_frames", SEL_FD, 1);
    expc("err_sticky", SEL_ERR, 1);
    tick();

    // Continuous run; a new start clears err; abort in frame 2.
    frame_cfg = 8'd0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    expc("err_cleared", SEL_ERR, 0);
    expc("cont_frames_clr", SEL_FD, 0);
    do_frame(1'b0, 3, 1'b0, 1);
    expc("f2_core_start", SEL_CS, 1);
    tick();
    stream_frame(1'b0, 1'b0, 5);
    abort = 1'b1;
    #2;
    expc("abort_s_tready", SEL_STR, 0);
    tick();
    abort = 1'b0;
    expc("abort_busy", SEL_BUSY, 0);
    expc("abort_frames", SEL_FD, 1);
    expc("abort_run_done", SEL_RD, 0);
    tick();
    expc("abort_run_done2", SEL_RD, 0);
    expc("abort_idle_cs", SEL_CS, 0);

    // Reset mid-stream with start held high, then a clean full frame.
    frame_cfg = 8'd1;
    start     = 1'b1;
    tick();
    expc("rs_core_start", SEL_CS, 1);
    tick();
    stream_frame(1'b0, 1'b0, 3);
    rst_n = 1'b0;
    #2;
    exp_all_zero("midrst");
    tick();
    exp_all_zero("midrst2");
    rst_n = 1'b1;
    tick();
    start = 1'b0;
    do_frame(1'b0, 3, 1'b1, 1);

    expc("pixels_left", SEL_PIXQ, 0);
    expc("stream_stall", SEL_TOF, 0);
    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
